// File: rtl/twp_master_arb.sv
// twp_master_arb: two-wire-protocol (TWP) master with a two-requester arbiter.
// One request is granted when the block is idle, and the winner's command,
// address and write data are latched in that same cycle. The master then sends
// start(0), cmd, addr[7:0] and, for writes, wdata[15:0], LSB first, on the
// single SDA line. For reads it releases SDA and waits for the slave's start
// marker (SDA low). It then shifts in 16 data bits, LSB first. If no marker
// arrives within TIMEOUT cycles the read is aborted with err. Every transaction
// ends with one DONE cycle (ack pulse) and GAP released-SDA guard cycles.
//
// Optional feature: define TWP_RR_EN for round-robin arbitration (a 1-bit
// pointer remembers the last grant; a tie goes to the other requester).
// Without it, requester 0 has fixed priority over requester 1.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   req      per-requester level request, held until its ack
//   cmd      per-requester command, 1=write 0=read
//   addr     requester i address at [8i+7:8i]
//   wdata    requester i write data at [16i+15:16i]
//   ack      one-cycle completion pulse to the granted requester
//   rdata    read data, valid with ack; holds between reads
//   err      one-cycle pulse with ack on read timeout
//   busy     high in any state other than IDLE
//   sda      TWP data line; driven 0/1 or released (external pull-up)
module twp_master_arb #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned GAP     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  cmd,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RDATA,
    S_DONE,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        cmd_q;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] shift_q, shift_d;
  logic        tmo_q, tmo_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic        sda_oe_q, sda_oe_d;
  logic        sda_do_q, sda_do_d;
  logic        latch_en;
  logic        win;
  logic        sda_in;

  assign sda_in = sda;
  assign sda    = sda_oe_q ? sda_do_q : 1'bz;

`ifdef TWP_RR_EN
  logic ptr_q, ptr_d;

  // Pointer holds the last granted requester; on a tie the other one wins.
  assign win   = (req == 2'b11) ? ~ptr_q : req[1];
  assign ptr_d = latch_en ? win : ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign win = req[1] & ~req[0];
`endif

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    gnt_d    = gnt_q;
    latch_en = 1'b0;
    shift_d  = shift_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d  = S_START;
          latch_en = 1'b1;
          gnt_d    = win;
          tmo_d    = 1'b0;
        end
      end
      S_START: state_d = S_CMD;
      S_CMD:   state_d = S_ADDR;
      S_ADDR: begin
        if (cnt_q == 8'd7) begin
          state_d = cmd_q ? S_WDATA : S_WAIT;
        end
      end
      S_WDATA: begin
        if (cnt_q == 8'd15) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (sda_in == 1'b0) begin
          state_d = S_RDATA;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      S_RDATA: begin
        shift_d = {sda_in, shift_q[15:1]};
        if (cnt_q == 8'd15) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_GAP;
      S_GAP: begin
        if (cnt_q == 8'(GAP - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Every counter use restarts from zero in the state being entered.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // The SDA drive is computed for the state being entered and registered,
  // so sda never depends combinationally on any input.
  always_comb begin
    sda_oe_d = 1'b0;
    sda_do_d = 1'b0;
    unique case (state_d)
      S_START: begin
        sda_oe_d = 1'b1;
        sda_do_d = 1'b0;
      end
      S_CMD: begin
        sda_oe_d = 1'b1;
        sda_do_d = cmd_q;
      end
      S_ADDR: begin
        sda_oe_d = 1'b1;
        sda_do_d = addr_q[cnt_d[2:0]];
      end
      S_WDATA: begin
        sda_oe_d = 1'b1;
        sda_do_d = wdata_q[cnt_d[3:0]];
      end
      default: begin
        sda_oe_d = 1'b0;
        sda_do_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (state_d == S_DONE) begin
      ack_d = gnt_d ? 2'b10 : 2'b01;
      err_d = tmo_d;
      if (state_q == S_RDATA) begin
        rdata_d = shift_d;
      end else if (state_q == S_WAIT) begin
        rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      cmd_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      tmo_q    <= 1'b0;
      rdata_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      sda_oe_q <= 1'b0;
      sda_do_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      sda_oe_q <= sda_oe_d;
      sda_do_q <= sda_do_d;
      if (latch_en) begin
        cmd_q   <= win ? cmd[1] : cmd[0];
        addr_q  <= win ? addr[15:8] : addr[7:0];
        wdata_q <= win ? wdata[31:16] : wdata[15:0];
      end
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_twp_master_arb.sv
module tb_twp_master_arb;
  localparam int unsigned TO = 32;
  localparam int unsigned GP = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req;
  logic [1:0]  cmd;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  wire         sda;
  logic        s_oe;
  logic        s_do;

  int tests = 0;
  int fails = 0;

  // Reference state: slave register file, last read result, RR pointer.
  logic [15:0] mem [256];
  logic [15:0] rd_model;
  bit          ptr_m;

  pullup (sda);
  assign sda = s_oe ? s_do : 1'bz;

  always #5 clk = ~clk;

  twp_master_arb #(.TIMEOUT(TO), .GAP(GP)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .cmd    (cmd),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .err    (err),
    .busy   (busy),
    .sda    (sda)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] rv);
    if (rv == 2'b11) begin
`ifdef TWP_RR_EN
      return ptr_m ? 0 : 1;
`else
      return 0;
`endif
    end
    return rv[1] ? 1 : 0;
  endfunction

  task automatic rand_fields(input int r);
    cmd[r]            = 1'($urandom_range(0, 1));
    addr[8*r +: 8]    = 8'($urandom_range(0, 15));
    wdata[16*r +: 16] = 16'($urandom);
  endtask

  // Runs one transaction starting at the current negedge (cycle 0, DUT idle,
  // req nonzero) and returns at the negedge of the following idle cycle.
  // hold: 0 = requester drops its req at ack, 1 = keeps it, 2 = all drop.
  task automatic serve(input int hold, input bit drop_early, input bit dead,
                       input int md, input bit raise, output int g);
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] word;
    logic [7:0]  cap_a;
    logic [15:0] cap_d;
    logic        exp_b;
    logic [1:0]  exp_ack;
    int          c;
    int          expc;
    bit          done;
    g       = pick(req);
    ptr_m   = g[0];
    wr      = cmd[g];
    a       = addr[8*g +: 8];
    d       = wdata[16*g +: 16];
    exp_ack = (g == 1) ? 2'b10 : 2'b01;
    cap_a   = '0;
    cap_d   = '0;
    for (c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) exp_b = 1'b0;
      else if (c == 2) exp_b = wr;
      else exp_b = a[c-3];
      check("busy_hdr", busy, 1);
      check("ack_hdr", ack, 0);
      check("sda_hdr", sda, exp_b);
      if (c >= 3) cap_a[c-3] = sda;
      if (c == 2 && drop_early) req[g] = 1'b0;
      if (c == 5 && raise && !req[1-g]) begin
        rand_fields(1 - g);
        req[1-g] = 1'b1;
      end
    end
    if (wr) begin
      for (c = 11; c <= 26; c++) begin
        @(negedge clk);
        check("sda_wdata", sda, d[c-11]);
        cap_d[c-11] = sda;
      end
      @(negedge clk);
      check("ack_wr", ack, exp_ack);
      check("err_wr", err, 0);
      check("rdata_wr", rdata, rd_model);
      check("sda_done", sda, 1);
      mem[cap_a] = cap_d;
    end else begin
      word = mem[cap_a];
      expc = dead ? 11 + TO : 28 + md;
      done = 1'b0;
      c    = 10;
      while (!done && c < 11 + TO + 24) begin
        @(negedge clk);
        c++;
        if (ack !== 2'b00) begin
          done = 1'b1;
        end else begin
          if (dead || c <= 11 + md) check("sda_rel", sda, 1);
          if (!dead) begin
            if (c == 11 + md) begin
              s_oe = 1'b1;
              s_do = 1'b0;
            end else if (c >= 12 + md && c <= 27 + md) begin
              s_oe = 1'b1;
              s_do = word[c-12-md];
            end
          end
        end
      end
      s_oe = 1'b0;
      check("ack_seen", done, 1);
      check("ack_cycle", c, expc);
      rd_model = dead ? 16'h0000 : word;
      check("ack_rd", ack, exp_ack);
      check("err_rd", err, dead);
      check("rdata_rd", rdata, rd_model);
    end
    if (hold == 0) req[g] = 1'b0;
    else if (hold == 2) req = 2'b00;
    for (int k = 0; k < int'(GP); k++) begin
      @(negedge clk);
      check("busy_gap", busy, 1);
      check("ack_gap", ack, 0);
      check("sda_gap", sda, 1);
    end
    @(negedge clk);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int g;
    int g0, g1, g2;
    logic [1:0] rv;
    reset_n  = 1'b0;
    req      = '0;
    cmd      = '0;
    addr     = '0;
    wdata    = '0;
    s_oe     = 1'b0;
    s_do     = 1'b0;
    rd_model = '0;
    ptr_m    = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Write by requester 0: 8'h5A <= 16'hA5C3.
    cmd[0] = 1'b1; addr[7:0] = 8'h5A; wdata[15:0] = 16'hA5C3;
    req = 2'b01;
    serve(0, 0, 0, 0, 0, g);
    check("grant_w0", g, 0);

    // Read by requester 1 of 8'h5A, marker at cycle 14, ack at 31.
    cmd[1] = 1'b0; addr[15:8] = 8'h5A;
    req = 2'b10;
    serve(0, 0, 0, 3, 0, g);
    check("grant_r1", g, 1);
    check("rdata_5a", rdata, 16'hA5C3);

    // Read with no slave marker: timeout.
    cmd[1] = 1'b0; addr[15:8] = 8'h10;
    req = 2'b10;
    serve(0, 0, 1, 0, 0, g);
    check("rdata_tmo", rdata, 16'h0000);

    // Both requesters held.
    cmd = 2'b11; addr = {8'h22, 8'h11}; wdata = 32'h1234_ABCD;
    req = 2'b11;
    serve(1, 0, 0, 0, 0, g0);
    serve(1, 0, 0, 0, 0, g1);
    serve(2, 0, 0, 0, 0, g2);
    check("tie_g0", g0, 0);
`ifdef TWP_RR_EN
    check("tie_g1", g1, 1);
`else
    check("tie_g1", g1, 0);
`endif
    check("tie_g2", g2, 0);

    // req dropped right after grant still completes with ack.
    cmd[0] = 1'b1; addr[7:0] = 8'h33; wdata[15:0] = 16'h0F0F;
    req = 2'b01;
    serve(0, 1, 0, 0, 0, g);

    // Reset in the middle of a write.
    cmd[0] = 1'b1; addr[7:0] = 8'h44; wdata[15:0] = 16'hBEEF;
    req = 2'b01;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sda", sda, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    req      = 2'b00;
    ptr_m    = 1'b1;
    rd_model = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdata", rdata, 0);
    check("post_rst_busy", busy, 0);
    req = 2'b01;
    serve(0, 0, 0, 0, 0, g);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if (req == 2'b00) begin
        rv = 2'($urandom_range(1, 3));
        for (int r = 0; r < 2; r++) if (rv[r]) rand_fields(r);
        req = rv;
      end
      serve(0, 0, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 6)),
            ($urandom_range(0, 3) == 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
